// File: rtl/regfile_param.sv
// Parametrised register bank with byte-lane writes, optional write-to-read bypass
// and a one-entry-per-cycle sweep-clear sequencer.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [ADDR_W-1:0]     ReadAddr1,
  input  logic [ADDR_W-1:0]     ReadAddr2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  input  logic [ADDR_W-1:0]     WriteAddr,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [DATA_W/8-1:0]   WriteByteEn,
  input  logic                  RegWrite,
  input  logic                  ClearReq,
  output logic                  ClearBusy,
  output logic                  ClearDone,
  output logic                  WriteDropped
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W:0]   NREGS_X  = (ADDR_W + 1)'(NREGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] byte_mask;
  logic              write_ok;
  logic              sweep_last;
  logic              hit1;
  logic              hit2;

  // Addresses past the bank and the hardwired zero entry never hold data.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] resolve(
    input logic              valid,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] mask
  );
    logic [DATA_W-1:0] v;
    v = valid ? stored : '0;
    if (hit) v = (v & ~mask) | (wdata & mask);
    return v;
  endfunction

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < NBYTES; b++) byte_mask[8*b +: 8] = {8{WriteByteEn[b]}};
  end

  assign ClearBusy  = (state == CLEAR);
  assign write_ok   = RegWrite && (state == IDLE) && addr_valid(WriteAddr);
  assign sweep_last = (state == CLEAR) && (sweep_cnt == LAST_IDX);
  assign hit1       = (BYPASS != 0) && write_ok && (ReadAddr1 == WriteAddr);
  assign hit2       = (BYPASS != 0) && write_ok && (ReadAddr2 == WriteAddr);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ClearReq) state_next = CLEAR;
      CLEAR: if (sweep_cnt == LAST_IDX) state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      sweep_cnt    <= '0;
      ClearDone    <= 1'b0;
      WriteDropped <= 1'b0;
    end else begin
      state        <= state_next;
      ClearDone    <= sweep_last;
      WriteDropped <= RegWrite && (state == CLEAR);
      if (state == IDLE) sweep_cnt <= '0;
      else               sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // The sweep owns the write path while busy, so a normal write can never collide with it.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[sweep_cnt] <= '0;
    end else if (write_ok) begin
      regs[WriteAddr] <= (regs[WriteAddr] & ~byte_mask) | (WriteData & byte_mask);
    end
  end

  assign ReadData1 = Reset_n ? resolve(addr_valid(ReadAddr1), regs[ReadAddr1], hit1, WriteData, byte_mask) : '0;
  assign ReadData2 = Reset_n ? resolve(addr_valid(ReadAddr2), regs[ReadAddr2], hit2, WriteData, byte_mask) : '0;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a 32-entry bypassing bank and a 24-entry
// non-bypassing bank share stimulus; a negedge monitor drains expected values.
module tb_regfile_param;

  localparam int RD1A = 0, RD2A = 1, BUSY = 2, DONE = 3, DROP = 4, RD1B = 5, RD2B = 6;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic        Clock = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        we, clr;

  logic [31:0] rd1a, rd2a, rd1b, rd2b;
  logic        busya, donea, dropa, busyb, doneb, dropb;

  exp_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 Clock = ~Clock;

  regfile_param #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .Clock(Clock), .Reset_n(rst_n), .ReadAddr1(ra1), .ReadAddr2(ra2),
    .ReadData1(rd1a), .ReadData2(rd2a), .WriteAddr(wa), .WriteData(wd),
    .WriteByteEn(be), .RegWrite(we), .ClearReq(clr), .ClearBusy(busya),
    .ClearDone(donea), .WriteDropped(dropa)
  );

  regfile_param #(.DATA_W(32), .NREGS(24), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .Clock(Clock), .Reset_n(rst_n), .ReadAddr1(ra1), .ReadAddr2(ra2),
    .ReadData1(rd1b), .ReadData2(rd2b), .WriteAddr(wa), .WriteData(wd),
    .WriteByteEn(be), .RegWrite(we), .ClearReq(clr), .ClearBusy(busyb),
    .ClearDone(doneb), .WriteDropped(dropb)
  );

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      RD1A:    return rd1a;
      RD2A:    return rd2a;
      BUSY:    return {31'b0, busya};
      DONE:    return {31'b0, donea};
      DROP:    return {31'b0, dropa};
      RD1B:    return rd1b;
      default: return rd2b;
    endcase
  endfunction

  // Every expectation queued during a cycle is compared at that cycle's falling edge.
  always @(negedge Clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = pick(e.sel);
      tests++;
      if (act !== e.exp) begin
        failed++;
        $display("[TB] FAIL %s: got %h expected %h", e.tag, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input int sel, input string tag, input logic [31:0] exp);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] e, input logic c);
    we  = w;
    wa  = a;
    wd  = d;
    be  = e;
    clr = c;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge Clock);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    ra1 = 5;
    ra2 = 0;
    tick();
    tick();
    checkOutput(BUSY, "reset busy", 0);
    checkOutput(DONE, "reset done", 0);
    checkOutput(DROP, "reset dropped", 0);
    checkOutput(RD1A, "reset read a", 0);
    checkOutput(RD1B, "reset read b", 0);
    releaseReset();

    // Fill every entry, then pulse reset mid-cycle.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 5'(i), 32'hA5A5A5A5, 4'hF, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0);
    ra1 = 0;
    ra2 = 31;
    checkOutput(RD1A, "fill r0 hardwired", 0);
    checkOutput(RD2A, "fill r31", 32'hA5A5A5A5);
    checkOutput(RD2B, "fill b addr31 out of range", 0);
    tick();
    ra1 = 5;
    checkOutput(RD1B, "fill b r5", 32'hA5A5A5A5);
    tick();
    rst_n = 1'b0;
    checkOutput(RD1A, "mid reset r5", 0);
    checkOutput(RD2A, "mid reset r31", 0);
    checkOutput(BUSY, "mid reset busy", 0);
    checkOutput(RD1B, "mid reset b r5", 0);
    releaseReset();

    // Byte-lane merge, bypassed on bank A and held off on bank B.
    applyStimulus(1, 5, 32'h11223344, 4'hF, 0);
    tick();
    applyStimulus(1, 5, 32'hAABBCCDD, 4'b0101, 0);
    ra1 = 5;
    checkOutput(RD1A, "be bypass merge", 32'h11BB33DD);
    checkOutput(RD1B, "be no bypass", 32'h11223344);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput(RD1A, "be stored a", 32'h11BB33DD);
    checkOutput(RD1B, "be stored b", 32'h11BB33DD);
    tick();

    // Zero register and out-of-range writes.
    applyStimulus(1, 0, 32'hFFFFFFFF, 4'hF, 0);
    ra1 = 0;
    checkOutput(RD1A, "r0 write no bypass", 0);
    tick();
    applyStimulus(1, 30, 32'h12345678, 4'hF, 0);
    ra1 = 30;
    checkOutput(RD1A, "r30 bypass a", 32'h12345678);
    checkOutput(RD1B, "addr30 b during write", 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    ra1 = 0;
    ra2 = 30;
    checkOutput(RD1A, "r0 after write", 0);
    checkOutput(RD2A, "r30 stored a", 32'h12345678);
    checkOutput(RD2B, "addr30 b after write", 0);
    tick();
    ra1 = 6;
    ra2 = 5;
    checkOutput(RD1B, "b r6 untouched", 0);
    checkOutput(RD2B, "b r5 untouched", 32'h11BB33DD);
    tick();

    // Dual-port bypass and a byte-enable-free write.
    applyStimulus(1, 7, 32'hDEADBEEF, 4'hF, 0);
    ra1 = 7;
    ra2 = 7;
    checkOutput(RD1A, "bypass port1", 32'hDEADBEEF);
    checkOutput(RD2A, "bypass port2", 32'hDEADBEEF);
    checkOutput(RD1B, "no bypass port1", 0);
    checkOutput(RD2B, "no bypass port2", 0);
    tick();
    applyStimulus(1, 7, 32'h0, 4'h0, 0);
    checkOutput(RD1A, "be0 bypass", 32'hDEADBEEF);
    checkOutput(RD2B, "b r7 after edge", 32'hDEADBEEF);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput(RD1A, "be0 stored", 32'hDEADBEEF);
    tick();

    // Sweep-clear; the request edge also carries an accepted write to r31.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1, 5'(i), 32'h100 + 32'(i), 4'hF, 0);
      tick();
    end
    applyStimulus(1, 31, 32'hCAFEF00D, 4'hF, 1);
    checkOutput(BUSY, "busy before request edge", 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    for (int j = 1; j <= 32; j++) begin
      checkOutput(BUSY, $sformatf("sweep busy k+%0d", j), 1);
      checkOutput(DONE, $sformatf("sweep done k+%0d", j), 0);
      clr = (j == 5);
      we  = 1'b0;
      if (j == 5) begin
        ra1 = 31;
        checkOutput(RD1A, "r31 write on request edge", 32'hCAFEF00D);
      end
      if (j == 10) begin
        applyStimulus(1, 3, 32'hFFFFFFFF, 4'hF, 0);
        ra1 = 3;
        ra2 = 20;
        checkOutput(RD1A, "dropped write no bypass", 0);
        checkOutput(RD2A, "unswept r20", 32'h114);
        checkOutput(DROP, "dropped before pulse", 0);
      end
      if (j == 11) checkOutput(DROP, "dropped pulse", 1);
      if (j == 12) checkOutput(DROP, "dropped single pulse", 0);
      tick();
    end
    checkOutput(BUSY, "busy after sweep", 0);
    checkOutput(DONE, "done pulse", 1);
    applyStimulus(1, 30, 32'h30303030, 4'hF, 1);
    ra1 = 31;
    ra2 = 3;
    checkOutput(RD1A, "r31 swept", 0);
    checkOutput(RD2A, "r3 swept", 0);
    tick();

    // Restart on the done cycle, then abort with reset.
    applyStimulus(0, 0, 0, 0, 0);
    ra1 = 20;
    checkOutput(BUSY, "restart on done cycle", 1);
    checkOutput(DONE, "done single pulse", 0);
    checkOutput(RD1A, "r20 swept", 0);
    for (int m = 1; m <= 7; m++) begin
      if (m == 3) begin
        ra1 = 30;
        checkOutput(RD1A, "r30 written on restart edge", 32'h30303030);
      end
      tick();
    end
    rst_n = 1'b0;
    checkOutput(RD1A, "abort r30 cleared", 0);
    checkOutput(BUSY, "abort busy", 0);
    checkOutput(DONE, "abort done", 0);
    releaseReset();
    applyStimulus(1, 4, 32'h44444444, 4'hF, 0);
    checkOutput(BUSY, "idle after abort", 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    ra1 = 4;
    ra2 = 30;
    checkOutput(RD1A, "write after abort", 32'h44444444);
    checkOutput(RD2A, "r30 after abort", 0);
    checkOutput(DROP, "no drop after abort", 0);
    tick();
    for (int m = 0; m < 30; m++) begin
      checkOutput(DONE, $sformatf("no done after abort +%0d", m), 0);
      tick();
    end
    tick();

    // Final direct checks on the idle bank and the drained scoreboard.
    tests++;
    if (busya !== 1'b0) begin
      failed++;
      $display("[TB] FAIL final busy: got %b expected 0", busya);
    end
    tests++;
    if (donea !== 1'b0) begin
      failed++;
      $display("[TB] FAIL final done: got %b expected 0", donea);
    end
    tests++;
    if (dropa !== 1'b0) begin
      failed++;
      $display("[TB] FAIL final dropped: got %b expected 0", dropa);
    end
    tests++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard not drained: %0d pending", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
